glb_iact_responder: RTL and testbench
=====================================

# glb_iact_responder

Global-buffer-side responder for the input-activation read channel. It holds one tile of input activations loaded by the fill path. It serves single-word read requests from the west iact router, whose address and request outputs drive this block. It returns data with an enable strobe that drives the router's data and enable inputs. A fill/ready state machine gates reads, and a fixed 2-cycle read pipeline delivers the data.

## Interface
- DATA_BITWIDTH, 16, activation word width
- ADDR_BITWIDTH_GLB, 10, read address width; buffer depth DEPTH = 2^ADDR_BITWIDTH_GLB
- BASE_ADDR, 100, GLB address mapped to buffer index 0
- RD_CNT_WIDTH, 16, width of served-read counter

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- clear  in  1  pulse; return to EMPTY, clear err and rd_count
- fill_start  in  1  pulse; begin loading fill_len words
- fill_len  in  ADDR_BITWIDTH_GLB+1  word count, sampled on fill_start
- w_data  in  DATA_BITWIDTH  fill word
- w_en  in  1  fill word valid
- fill_done  out  1  one-cycle pulse when the last fill word is committed
- ready  out  1  high while state is READY
- r_addr  in  ADDR_BITWIDTH_GLB  read address from router
- r_req  in  1  read request from router, one word per cycle
- r_data  out  DATA_BITWIDTH  read data to router
- r_valid  out  1  read data strobe to router
- rd_count  out  RD_CNT_WIDTH  served reads, saturating
- err  out  1  sticky: rejected request seen

## Operation
- States: EMPTY, FILLING, READY.
  - EMPTY -> FILLING on fill_start.
  - FILLING -> READY on the edge that commits word fill_len-1.
  - Any state -> FILLING on fill_start (restart).
  - Any state -> EMPTY on clear.
- fill_start with fill_len = 0 goes directly to READY and pulses fill_done.
- fill_len > DEPTH is clamped to DEPTH.
- Fill: each w_en in FILLING writes w_data at index wr_cnt, then increments wr_cnt. wr_cnt resets to 0 on fill_start. w_en outside FILLING is ignored.
- Read index: idx = (r_addr - BASE_ADDR) mod DEPTH, computed at ADDR_BITWIDTH_GLB bits.
- A request is accepted if state == READY and idx < fill_len_q. Otherwise it is rejected: no r_valid, and err is set.
- Accepted request: r_data = mem[idx], r_valid = 1. r_data is 0 whenever r_valid = 0.
- rd_count increments on every r_valid and holds at all-ones.
- Requests already accepted complete even if fill_start or clear arrives afterwards.
- Memory is read-first: a fill write to the same index in the read cycle returns the old data.
- Simultaneous events:
  - clear together with fill_start: clear wins.
  - fill_start together with w_en: w_en is ignored and the fill restarts at index 0.
- Reset values: state EMPTY, wr_cnt 0, fill_done 0, ready 0, r_valid 0, r_data 0, rd_count 0, err 0. Reset also drops in-flight reads.

## Timing
- Read latency is 2 cycles.
  - r_req sampled at edge T: index and accept are registered in stage 1.
  - Synchronous memory read at edge T+1.
  - r_data/r_valid are visible after edge T+2.
- Back-to-back requests give back-to-back r_valid, throughput 1 word/cycle. There is no backpressure.
- err rises after edge T+1 for a request rejected at T.
- ready and fill_done rise after the edge committing the last word. fill_done falls one cycle later.

## Configuration
- GLB_IACT_EARLY_READ_EN defined: reads are also accepted in FILLING when idx < wr_cnt, the count of words committed before the request edge.
  - A request for the index being written in the same cycle is rejected.
  - This allows the router to stream while the fill is still in progress.
- Not defined: every request outside READY is rejected.

## Structure
- Package glb_iact_pkg holds:
  - state encoding: EMPTY = 2'd0, FILLING = 2'd1, READY = 2'd2
  - RD_LATENCY = 2
- Sub-module glb_sram_1r1w: DEPTH x DATA_BITWIDTH, synchronous read, read-first. The responder instantiates one.

## Test plan
- Fill 25 words with values 1..25 (fill_len = 25), then request r_addr 100..124 back-to-back -> r_valid for 25 consecutive cycles starting 2 cycles after the first request, r_data 1..25, rd_count = 25, err = 0.
- Request r_addr 125 in READY with fill_len = 25 -> no r_valid, err = 1 one cycle later; clear -> err = 0.
- Request r_addr 100 in EMPTY -> no r_valid, err = 1.
- Early read, with the macro defined: write word 0 = 7, then at the edge writing word 1 request r_addr 100 and r_addr 101 on consecutive cycles -> r_data 7 with r_valid; the r_addr 101 request is rejected. With the macro undefined, both are rejected.
- fill_len = 0 -> ready and fill_done on the cycle after fill_start. fill_len = 2000 -> clamped, fill_done after 1024 writes.
- Assert reset during a read burst -> r_valid = 0 next cycle and all outputs at reset values. fill_start during a burst -> requests accepted before it complete, later ones are rejected.

Source files
------------

// File: rtl/glb_iact_pkg.sv
// rtl/glb_iact_pkg.sv - shared state encoding and read latency for the GLB iact responder
package glb_iact_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2
    } state_e;

    localparam int RD_LATENCY = 2;

endpackage

// File: rtl/glb_sram_1r1w.sv
// rtl/glb_sram_1r1w.sv - DEPTH x DATA_W one-read one-write synchronous SRAM, read-first
module glb_sram_1r1w #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Both updates are non-blocking, so a same-address write lands after the read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/glb_iact_responder.sv
// rtl/glb_iact_responder.sv - GLB-side iact read responder: tile fill FSM plus 2-cycle read pipe
// Optional GLB_IACT_EARLY_READ_EN: serve already-committed words while FILLING.
module glb_iact_responder
    import glb_iact_pkg::*;
#(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int BASE_ADDR         = 100,
    parameter int RD_CNT_WIDTH      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         fill_start,
    input  logic [ADDR_BITWIDTH_GLB:0]   fill_len,
    input  logic [DATA_BITWIDTH-1:0]     w_data,
    input  logic                         w_en,
    output logic                         fill_done,
    output logic                         ready,
    input  logic [ADDR_BITWIDTH_GLB-1:0] r_addr,
    input  logic                         r_req,
    output logic [DATA_BITWIDTH-1:0]     r_data,
    output logic                         r_valid,
    output logic [RD_CNT_WIDTH-1:0]      rd_count,
    output logic                         err
);

    localparam int AW = ADDR_BITWIDTH_GLB;
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(1 << AW);
    localparam logic [AW-1:0] BASE_L  = AW'(BASE_ADDR);

    state_e                  state_q;
    logic [AW:0]             wr_cnt_q;
    logic [AW:0]             fill_len_q;
    logic                    fill_done_q;

    logic [RD_LATENCY-1:0]   vld_q;
    logic [AW-1:0]           idx_q;
    logic                    rej_q;
    logic                    r_valid_q;
    logic [DATA_BITWIDTH-1:0] r_data_q;
    logic [RD_CNT_WIDTH-1:0] rd_count_q;
    logic                    err_q;

    logic [AW:0]             fill_len_clamp;
    logic                    wr_fire;
    logic                    last_word;
    logic [AW-1:0]           idx;
    logic                    accept;
    logic                    reject;
    logic [DATA_BITWIDTH-1:0] sram_rdata;

    assign fill_len_clamp = (fill_len > DEPTH_L) ? DEPTH_L : fill_len;
    assign wr_fire        = (state_q == FILLING) && w_en && !fill_start && !clear;
    assign last_word      = (wr_cnt_q == (fill_len_q - (AW+1)'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            wr_cnt_q    <= '0;
            fill_len_q  <= '0;
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= 1'b0;
            if (clear) begin
                state_q    <= EMPTY;
                wr_cnt_q   <= '0;
                fill_len_q <= '0;
            end else if (fill_start) begin
                wr_cnt_q   <= '0;
                fill_len_q <= fill_len_clamp;
                if (fill_len_clamp == '0) begin
                    state_q     <= READY;
                    fill_done_q <= 1'b1;
                end else begin
                    state_q <= FILLING;
                end
            end else if (wr_fire) begin
                wr_cnt_q <= wr_cnt_q + (AW+1)'(1);
                if (last_word) begin
                    state_q     <= READY;
                    fill_done_q <= 1'b1;
                end
            end
        end
    end

    // Modulo-DEPTH subtraction lets addresses below BASE_ADDR wrap to the top of the tile.
    assign idx = r_addr - BASE_L;

`ifdef GLB_IACT_EARLY_READ_EN
    assign accept = r_req && (((state_q == READY) && ({1'b0, idx} < fill_len_q)) ||
                              ((state_q == FILLING) && ({1'b0, idx} < wr_cnt_q)));
`else
    assign accept = r_req && (state_q == READY) && ({1'b0, idx} < fill_len_q);
`endif
    assign reject = r_req && !accept;

    // Only reset flushes the pipe; clear and fill_start let accepted reads finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q      <= '0;
            idx_q      <= '0;
            rej_q      <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            rd_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            vld_q     <= {vld_q[RD_LATENCY-2:0], accept};
            idx_q     <= idx;
            rej_q     <= reject;
            r_valid_q <= vld_q[RD_LATENCY-1];
            r_data_q  <= vld_q[RD_LATENCY-1] ? sram_rdata : '0;
            if (clear) begin
                err_q      <= 1'b0;
                rd_count_q <= '0;
            end else begin
                if (rej_q) begin
                    err_q <= 1'b1;
                end
                if (vld_q[RD_LATENCY-1] && (rd_count_q != '1)) begin
                    rd_count_q <= rd_count_q + RD_CNT_WIDTH'(1);
                end
            end
        end
    end

    glb_sram_1r1w #(
        .DATA_W (DATA_BITWIDTH),
        .ADDR_W (AW)
    ) u_sram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_cnt_q[AW-1:0]),
        .wr_data (w_data),
        .rd_en   (vld_q[0]),
        .rd_addr (idx_q),
        .rd_data (sram_rdata)
    );

    assign fill_done = fill_done_q;
    assign ready     = (state_q == READY);
    assign r_valid   = r_valid_q;
    assign r_data    = r_data_q;
    assign rd_count  = rd_count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_glb_iact_responder.sv
// tb/tb_glb_iact_responder.sv - directed self-checking bench for glb_iact_responder
module tb_glb_iact_responder;

`ifdef GLB_IACT_EARLY_READ_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        fill_start = 1'b0;
    logic [10:0] fill_len = '0;
    logic [15:0] w_data = '0;
    logic        w_en = 1'b0;
    logic        fill_done;
    logic        ready;
    logic [9:0]  r_addr = '0;
    logic        r_req = 1'b0;
    logic [15:0] r_data;
    logic        r_valid;
    logic [15:0] rd_count;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    glb_iact_responder dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .fill_start (fill_start),
        .fill_len   (fill_len),
        .w_data     (w_data),
        .w_en       (w_en),
        .fill_done  (fill_done),
        .ready      (ready),
        .r_addr     (r_addr),
        .r_req      (r_req),
        .r_data     (r_data),
        .r_valid    (r_valid),
        .rd_count   (rd_count),
        .err        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", ready, 0);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_data", r_data, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_err", err, 0);

        // Request while EMPTY is rejected
        r_req = 1'b1; r_addr = 10'd100;
        tick();
        r_req = 1'b0;
        chk("empty_err_T", err, 0);
        tick();
        chk("empty_err_T1", err, 1);
        tick();
        chk("empty_no_valid", r_valid, 0);
        pulse_clear();
        chk("empty_clear_err", err, 0);

        // Fill 25 words 1..25
        fill_start = 1'b1; fill_len = 11'd25;
        tick();
        fill_start = 1'b0;
        w_en = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            w_data = 16'(i);
            tick();
            if (i == 24) chk("fill25_not_ready", ready, 0);
        end
        w_en = 1'b0;
        chk("fill25_ready", ready, 1);
        chk("fill25_done", fill_done, 1);
        tick();
        chk("fill25_done_fall", fill_done, 0);
        chk("fill25_ready_hold", ready, 1);

        // Back-to-back burst r_addr 100..124
        for (int k = 0; k < 28; k++) begin
            r_req  = (k < 25);
            r_addr = 10'(100 + k);
            tick();
            if (k >= 2 && k <= 26) begin
                chk("burst_valid", r_valid, 1);
                chk("burst_data", r_data, 32'(k - 1));
            end else begin
                chk("burst_idle_valid", r_valid, 0);
                chk("burst_idle_data", r_data, 0);
            end
        end
        chk("burst_rd_count", rd_count, 25);
        chk("burst_err", err, 0);

        // Out-of-range request in READY
        r_req = 1'b1; r_addr = 10'd125;
        tick();
        r_req = 1'b0;
        chk("oor_err_T", err, 0);
        tick();
        chk("oor_err_T1", err, 1);
        tick();
        chk("oor_no_valid", r_valid, 0);
        chk("oor_rd_count", rd_count, 25);
        pulse_clear();
        chk("oor_clear_err", err, 0);
        chk("oor_clear_count", rd_count, 0);
        chk("oor_clear_ready", ready, 0);

        // Early read during fill
        fill_start = 1'b1; fill_len = 11'd4;
        tick();
        fill_start = 1'b0;
        w_en = 1'b1; w_data = 16'd7;
        tick();
        w_en = 1'b0;
        r_req = 1'b1; r_addr = 10'd100;
        tick();
        r_addr = 10'd101; w_en = 1'b1; w_data = 16'd8;
        tick();
        r_req = 1'b0; w_en = 1'b0;
        chk("early_err_first", err, EARLY ? 32'd0 : 32'd1);
        tick();
        chk("early_valid", r_valid, EARLY ? 32'd1 : 32'd0);
        chk("early_data", r_data, EARLY ? 32'd7 : 32'd0);
        chk("early_err_second", err, 1);
        tick();
        chk("early_reject_valid", r_valid, 0);
        pulse_clear();

        // clear wins over fill_start
        clear = 1'b1; fill_start = 1'b1; fill_len = 11'd0;
        tick();
        clear = 1'b0; fill_start = 1'b0;
        chk("clr_fs_ready", ready, 0);
        chk("clr_fs_done", fill_done, 0);

        // Zero-length fill
        fill_start = 1'b1; fill_len = 11'd0;
        tick();
        fill_start = 1'b0;
        chk("len0_ready", ready, 1);
        chk("len0_done", fill_done, 1);
        tick();
        chk("len0_done_fall", fill_done, 0);
        chk("len0_ready_hold", ready, 1);

        // w_en alongside fill_start is ignored
        fill_start = 1'b1; fill_len = 11'd1; w_en = 1'b1; w_data = 16'h0099;
        tick();
        fill_start = 1'b0; w_data = 16'h0033;
        chk("fs_wen_ignored", ready, 0);
        tick();
        w_en = 1'b0;
        chk("fs_wen_ready", ready, 1);
        chk("fs_wen_done", fill_done, 1);
        r_req = 1'b1; r_addr = 10'd100;
        tick();
        r_req = 1'b0;
        tick(); tick();
        chk("fs_wen_valid", r_valid, 1);
        chk("fs_wen_data", r_data, 32'h33);
        pulse_clear();

        // fill_len 2000 clamps to 1024
        fill_start = 1'b1; fill_len = 11'd2000;
        tick();
        fill_start = 1'b0;
        w_en = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            w_data = 16'(i) ^ 16'h5A5A;
            tick();
            if (i == 1022) begin
                chk("clamp_not_ready", ready, 0);
                chk("clamp_not_done", fill_done, 0);
            end
        end
        w_en = 1'b0;
        chk("clamp_ready", ready, 1);
        chk("clamp_done", fill_done, 1);
        r_req = 1'b1; r_addr = 10'd99;
        tick();
        r_req = 1'b0;
        tick(); tick();
        chk("wrap_valid", r_valid, 1);
        chk("wrap_data", r_data, 32'h59A5);
        chk("wrap_err", err, 0);

        // fill_start in the middle of a burst
        r_req = 1'b1; r_addr = 10'd100;
        tick();
        r_addr = 10'd101;
        tick();
        r_req = 1'b0; fill_start = 1'b1; fill_len = 11'd4;
        tick();
        fill_start = 1'b0;
        chk("fsb_valid0", r_valid, 1);
        chk("fsb_data0", r_data, 32'h5A5A);
        r_req = 1'b1; r_addr = 10'd103;
        tick();
        chk("fsb_valid1", r_valid, 1);
        chk("fsb_data1", r_data, 32'h5A5B);
        r_addr = 10'd104;
        tick();
        r_req = 1'b0;
        chk("fsb_valid2", r_valid, 0);
        chk("fsb_err", err, 1);
        tick();
        chk("fsb_valid3", r_valid, 0);
        tick();
        chk("fsb_valid4", r_valid, 0);
        chk("fsb_rd_count", rd_count, 3);

        // Reset during a burst
        pulse_clear();
        fill_start = 1'b1; fill_len = 11'd2;
        tick();
        fill_start = 1'b0;
        w_en = 1'b1; w_data = 16'h0011;
        tick();
        w_data = 16'h0022;
        tick();
        w_en = 1'b0;
        chk("rb_ready", ready, 1);
        r_req = 1'b1; r_addr = 10'd100;
        tick();
        r_addr = 10'd101;
        tick();
        r_addr = 10'd100;
        tick();
        chk("rb_valid", r_valid, 1);
        chk("rb_data", r_data, 32'h11);
        reset = 1'b1;
        tick();
        chk("rb_rst_valid", r_valid, 0);
        chk("rb_rst_data", r_data, 0);
        chk("rb_rst_ready", ready, 0);
        chk("rb_rst_count", rd_count, 0);
        chk("rb_rst_err", err, 0);
        chk("rb_rst_done", fill_done, 0);
        reset = 1'b0; r_req = 1'b0;
        tick();
        chk("rb_flush1", r_valid, 0);
        tick();
        chk("rb_flush2", r_valid, 0);
        chk("rb_flush_count", rd_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
